q65_stim_gen: RTL and testbench

Clocked, parametrised stimulus generator for the q65 test benches. It produces a bounded sequence of WIDTH-bit values in one of four run-time-selectable patterns: binary count, Gray code, Galois LFSR or walking one. Values are delivered over a valid/advance handshake so a DUT-side consumer can stall it. A start/done protocol lets a bench controller launch, abort and chain runs without `$finish`.

---
 rtl/q65_stim_gen.sv | 114 +++++++++++
 tb/tb_q65_stim_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q65_stim_gen.sv
// Parametrised stimulus generator: bounded COUNT / GRAY / LFSR / WALK sequences
// delivered over a valid/advance handshake, with a start/done/abort run protocol.
module q65_stim_gen #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [31:0]       NTICKS    = 32'd256,
  parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [31:0]      counter,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_COUNT, M_GRAY, M_LFSR, M_WALK} mode_t;

  state_t           state, state_n;
  mode_t            mode_r, mode_n;
  logic [WIDTH-1:0] out_r, out_n;
  logic [WIDTH-1:0] bin_r, bin_n;   // binary shadow of the Gray sequence
  logic [31:0]      cnt_r, cnt_n;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    out_n   = out_r;
    bin_n   = bin_r;
    cnt_n   = cnt_r;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_RUN;
          mode_n  = mode_t'(mode);
          cnt_n   = '0;
          bin_n   = seed;
          unique case (mode_t'(mode))
            M_COUNT: out_n = seed;
            M_GRAY:  out_n = to_gray(seed);
            M_LFSR:  out_n = (seed == '0) ? WIDTH'(1) : seed;  // all-zero LFSR state locks up
            M_WALK:  out_n = WIDTH'(1);
          endcase
        end
      end
      S_RUN: begin
        if (advance) begin
          if (cnt_r == NTICKS - 32'd1) begin
            // Final transfer: out keeps the last delivered value.
            state_n = S_DONE;
            cnt_n   = NTICKS;
          end else begin
            cnt_n = cnt_r + 32'd1;
            unique case (mode_r)
              M_COUNT: out_n = out_r + WIDTH'(1);
              M_GRAY: begin
                bin_n = bin_r + WIDTH'(1);
                out_n = to_gray(bin_n);
              end
              M_LFSR:  out_n = (out_r >> 1) ^ (out_r[0] ? LFSR_TAPS : '0);
              M_WALK:  out_n = (out_r << 1) | (out_r >> (WIDTH - 1));
            endcase
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n = S_IDLE;
      mode_n  = M_COUNT;
      out_n   = '0;
      bin_n   = '0;
      cnt_n   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_r <= M_COUNT;
      out_r  <= '0;
      bin_r  <= '0;
      cnt_r  <= '0;
    end else begin
      state  <= state_n;
      mode_r <= mode_n;
      out_r  <= out_n;
      bin_r  <= bin_n;
      cnt_r  <= cnt_n;
    end
  end

  // Handshake outputs decode registered state only; advance never reaches valid combinationally.
  assign out     = out_r;
  assign counter = cnt_r;
  assign valid   = (state == S_RUN);
  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_q65_stim_gen.sv
// Scoreboard bench for q65_stim_gen: four instances (COUNT/LFSR/WALK/GRAY setups)
// driven one at a time; a negedge monitor compares every presented value.
module tb_q65_stim_gen;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_s [NI];
  logic        abort_s [NI];
  logic        adv_s   [NI];
  logic [1:0]  mode_s  [NI];
  logic [31:0] seed_s  [NI];

  logic [31:0] obs_out   [NI];
  logic [31:0] obs_cnt   [NI];
  logic        obs_valid [NI];
  logic        obs_busy  [NI];
  logic        obs_done  [NI];

  logic [3:0] out0;
  logic [7:0] out1;
  logic [3:0] out2;
  logic [2:0] out3;

  assign obs_out[0] = 32'(out0);
  assign obs_out[1] = 32'(out1);
  assign obs_out[2] = 32'(out2);
  assign obs_out[3] = 32'(out3);

  q65_stim_gen #(.WIDTH(4), .NTICKS(32'd20)) u_cnt (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .mode(mode_s[0]),
    .seed(seed_s[0][3:0]), .advance(adv_s[0]), .out(out0), .valid(obs_valid[0]),
    .counter(obs_cnt[0]), .busy(obs_busy[0]), .done(obs_done[0]));

  q65_stim_gen #(.WIDTH(8), .NTICKS(32'd256), .LFSR_TAPS(8'hB8)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .mode(mode_s[1]),
    .seed(seed_s[1][7:0]), .advance(adv_s[1]), .out(out1), .valid(obs_valid[1]),
    .counter(obs_cnt[1]), .busy(obs_busy[1]), .done(obs_done[1]));

  q65_stim_gen #(.WIDTH(4), .NTICKS(32'd6)) u_walk (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]), .mode(mode_s[2]),
    .seed(seed_s[2][3:0]), .advance(adv_s[2]), .out(out2), .valid(obs_valid[2]),
    .counter(obs_cnt[2]), .busy(obs_busy[2]), .done(obs_done[2]));

  q65_stim_gen #(.WIDTH(3), .NTICKS(32'd8)) u_gray (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .abort(abort_s[3]), .mode(mode_s[3]),
    .seed(seed_s[3][2:0]), .advance(adv_s[3]), .out(out3), .valid(obs_valid[3]),
    .counter(obs_cnt[3]), .busy(obs_busy[3]), .done(obs_done[3]));

  typedef struct {
    int          id;
    logic [31:0] val;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] v, input logic [31:0] c);
    exp_t e;
    e.id  = id;
    e.val = v;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: while valid, the presented value must match the scoreboard head;
  // the head is retired only when advance makes the transfer happen.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_n && obs_valid[i]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: instance %0d presented 0x%0h with nothing expected", i, obs_out[i]);
        end else begin
          check("sb_id", i, exp_q[0].id);
          check("sb_value", obs_out[i], exp_q[0].val);
          check("sb_counter", obs_cnt[i], exp_q[0].cnt);
          if (adv_s[i]) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic launch(input int id, input logic [1:0] m, input logic [31:0] s);
    start_s[id] = 1'b1;
    mode_s[id]  = m;
    seed_s[id]  = s;
    @(posedge clk); #1;
    start_s[id] = 1'b0;
    mode_s[id]  = 2'd0;
    seed_s[id]  = 32'hFFFF_FFFF;
    check("launch_valid", 32'(obs_valid[id]), 32'd1);
    check("launch_busy", 32'(obs_busy[id]), 32'd1);
    check("launch_done", 32'(obs_done[id]), 32'd0);
    check("launch_counter", obs_cnt[id], 32'd0);
  endtask

  task automatic drive_until_done(input int id, input bit stall, input int budget, output int cycles);
    cycles = 0;
    while (!obs_done[id] && cycles < budget) begin
      adv_s[id] = stall ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    adv_s[id] = 1'b0;
    if (!obs_done[id]) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: instance %0d no done within %0d cycles", id, budget);
    end
  endtask

  task automatic finish_check(input int id, input int cycles, input int exp_cycles,
                              input logic [31:0] ntick, input logic [31:0] last);
    check("done_latency", cycles, exp_cycles);
    check("done_flag", 32'(obs_done[id]), 32'd1);
    check("done_valid", 32'(obs_valid[id]), 32'd0);
    check("done_busy", 32'(obs_busy[id]), 32'd0);
    check("done_counter", obs_cnt[id], ntick);
    check("done_out", obs_out[id], last);
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [7:0] lv;
    logic [2:0] gray_tab [8];
    logic [3:0] walk_tab [6];
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    walk_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};

    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; adv_s[i] = 1'b0;
      mode_s[i] = 2'd0;  seed_s[i] = '0;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < NI; i++) begin
      check("rst_out", obs_out[i], 32'd0);
      check("rst_valid", 32'(obs_valid[i]), 32'd0);
      check("rst_counter", obs_cnt[i], 32'd0);
      check("rst_busy", 32'(obs_busy[i]), 32'd0);
      check("rst_done", 32'(obs_done[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // COUNT, WIDTH=4, 20 ticks from seed 0: 0..15 then wraps to 0..3.
    for (int i = 0; i < 20; i++) push_exp(0, 32'(i % 16), 32'(i));
    launch(0, 2'd0, 32'd0);
    drive_until_done(0, 1'b0, 40, cyc);
    finish_check(0, cyc, 20, 32'd20, 32'd3);

    // LFSR, WIDTH=8, seed 0 -> first value 1, then 0xB8; 1 recurs at index 255.
    lv = 8'd1;
    for (int i = 0; i < 256; i++) begin
      push_exp(1, 32'(lv), 32'(i));
      lv = (lv >> 1) ^ (lv[0] ? 8'hB8 : 8'h00);
    end
    launch(1, 2'd2, 32'd0);
    check("lfsr_first", obs_out[1], 32'h01);
    adv_s[1] = 1'b1;
    @(posedge clk); #1;
    adv_s[1] = 1'b0;
    check("lfsr_second", obs_out[1], 32'hB8);
    drive_until_done(1, 1'b0, 300, cyc);
    finish_check(1, cyc, 255, 32'd256, 32'h01);

    // WALK, WIDTH=4, seed 0xF ignored.
    for (int i = 0; i < 6; i++) push_exp(2, 32'(walk_tab[i]), 32'(i));
    launch(2, 2'd3, 32'hF);
    drive_until_done(2, 1'b0, 20, cyc);
    finish_check(2, cyc, 6, 32'd6, 32'd2);

    // GRAY, WIDTH=3, seed 0.
    for (int i = 0; i < 8; i++) push_exp(3, 32'(gray_tab[i]), 32'(i));
    launch(3, 2'd1, 32'd0);
    drive_until_done(3, 1'b0, 20, cyc);
    finish_check(3, cyc, 8, 32'd8, 32'd4);

    // Restart from DONE, then a start pulse mid-run must be ignored.
    for (int i = 0; i < 20; i++) push_exp(0, 32'(i % 16), 32'(i));
    launch(0, 2'd0, 32'd0);
    adv_s[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start_s[0] = 1'b1; mode_s[0] = 2'd3; seed_s[0] = 32'd9;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    check("midstart_counter", obs_cnt[0], 32'd4);
    check("midstart_out", obs_out[0], 32'd4);
    drive_until_done(0, 1'b0, 40, cyc);
    finish_check(0, cyc, 16, 32'd20, 32'd3);

    // Stall: advance pattern 1,0,0,1 -> 20 transfers take 40 cycles.
    for (int i = 0; i < 20; i++) push_exp(0, 32'((5 + i) % 16), 32'(i));
    launch(0, 2'd0, 32'd5);
    drive_until_done(0, 1'b1, 100, cyc);
    finish_check(0, cyc, 40, 32'd20, 32'd8);

    // Abort at counter=5 together with a transfer: abort wins, no done.
    for (int i = 0; i < 6; i++) push_exp(0, 32'(i), 32'(i));
    launch(0, 2'd0, 32'd0);
    adv_s[0] = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("pre_abort_counter", obs_cnt[0], 32'd5);
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    adv_s[0] = 1'b0;
    check("abort_out", obs_out[0], 32'd0);
    check("abort_counter", obs_cnt[0], 32'd0);
    check("abort_valid", 32'(obs_valid[0]), 32'd0);
    check("abort_busy", 32'(obs_busy[0]), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_done", 32'(obs_done[0]), 32'd0);
    check("abort_drained", exp_q.size(), 32'd0);

    // Reset mid-run clears outputs at once; a new start restarts from seed.
    for (int i = 0; i < 3; i++) push_exp(0, 32'(3 + i), 32'(i));
    launch(0, 2'd0, 32'd3);
    adv_s[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    adv_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", obs_out[0], 32'd0);
    check("midrst_counter", obs_cnt[0], 32'd0);
    check("midrst_valid", 32'(obs_valid[0]), 32'd0);
    check("midrst_busy", 32'(obs_busy[0]), 32'd0);
    check("midrst_done", 32'(obs_done[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) push_exp(0, 32'((3 + i) % 16), 32'(i));
    launch(0, 2'd0, 32'd3);
    drive_until_done(0, 1'b0, 40, cyc);
    finish_check(0, cyc, 20, 32'd20, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
